// File: rtl/snake_score_keeper.sv
// Snake score keeper: tracks the game score and session high score and
// selects the 27-bit value fed to the seven-segment display stage.
module snake_score_keeper #(
    parameter int unsigned POINTS_PER_FOOD = 10,
    parameter int unsigned MAX_SCORE       = 99999999,
    parameter int unsigned ALT_CYCLES      = 100000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        eat,
    input  logic        game_over,
    input  logic        show_high,
    output logic [26:0] score,
    output logic [26:0] high_score,
    output logic [26:0] disp_value,
    output logic [1:0]  state,
    output logic        new_high
);

    localparam int unsigned      CNT_W    = (ALT_CYCLES > 1) ? $clog2(ALT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALT_CYCLES - 1);
    localparam logic [27:0]      PTS      = 28'(POINTS_PER_FOOD);
    localparam logic [27:0]      MAX_V    = 28'(MAX_SCORE);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PLAY = 2'b01,
        OVER = 2'b10
    } state_t;

    state_t             state_q, state_n;
    logic [26:0]        score_n, high_n, disp_n;
    logic               new_high_n;
    logic [CNT_W-1:0]   cnt_q, cnt_n;
    logic               phase_q, phase_n;
    logic               start_q, eat_q, go_q;
    logic               start_edge, eat_edge, go_edge;
    logic [27:0]        sum;
    logic [26:0]        inc_score, play_score;

    assign start_edge = start & ~start_q;
    assign eat_edge   = eat & ~eat_q;
    assign go_edge    = game_over & ~go_q;
    assign state      = state_q;

    // Saturating increment; the game-over compare sees the post-eat score
    // so a food taken on the final cycle still counts.
    always_comb begin
        sum        = {1'b0, score} + PTS;
        inc_score  = (sum > MAX_V) ? MAX_V[26:0] : sum[26:0];
        play_score = eat_edge ? inc_score : score;
    end

    // Next-state, score bookkeeping, alternation timer and display select.
    always_comb begin
        state_n    = state_q;
        score_n    = score;
        high_n     = high_score;
        new_high_n = new_high;
        cnt_n      = '0;
        phase_n    = 1'b0;
        if (state_q == OVER)
            disp_n = phase_q ? high_score : score;
        else
            disp_n = show_high ? high_score : score;

        case (state_q)
            IDLE: begin
                if (start_edge) begin
                    state_n    = PLAY;
                    score_n    = '0;
                    new_high_n = 1'b0;
                end
            end
            PLAY: begin
                score_n = play_score;
                if (go_edge) begin
                    state_n = OVER;
                    if (play_score > high_score) begin
                        high_n     = play_score;
                        new_high_n = 1'b1;
                    end
                end
            end
            OVER: begin
                if (start_edge) begin
                    state_n    = PLAY;
                    score_n    = '0;
                    new_high_n = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    phase_n = ~phase_q;
                end else begin
                    cnt_n   = cnt_q + 1'b1;
                    phase_n = phase_q;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State, score and edge-detect registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            score      <= '0;
            high_score <= '0;
            disp_value <= '0;
            new_high   <= 1'b0;
            cnt_q      <= '0;
            phase_q    <= 1'b0;
            start_q    <= 1'b0;
            eat_q      <= 1'b0;
            go_q       <= 1'b0;
        end else begin
            state_q    <= state_n;
            score      <= score_n;
            high_score <= high_n;
            disp_value <= disp_n;
            new_high   <= new_high_n;
            cnt_q      <= cnt_n;
            phase_q    <= phase_n;
            start_q    <= start;
            eat_q      <= eat;
            go_q       <= game_over;
        end
    end

endmodule

// File: tb/tb_snake_score_keeper.sv
// Scoreboard bench for snake_score_keeper: two instances (normal ceiling and
// a low ceiling of 25) share the same stimulus; a reference model pushes the
// expected outputs per clock and a monitor compares on the falling edge.
module tb_snake_score_keeper;

    localparam int unsigned ALT  = 4;
    localparam int unsigned PTS  = 10;
    localparam int unsigned MAXA = 99999999;
    localparam int unsigned MAXB = 25;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0, eat = 1'b0, game_over = 1'b0, show_high = 1'b0;

    logic [26:0] score_a, high_a, disp_a, score_b, high_b, disp_b;
    logic [1:0]  state_a, state_b;
    logic        nh_a, nh_b;

    always #5 clk = ~clk;

    snake_score_keeper #(.POINTS_PER_FOOD(PTS), .MAX_SCORE(MAXA), .ALT_CYCLES(ALT)) u_dut_a (
        .clk(clk), .rst(rst), .start(start), .eat(eat), .game_over(game_over),
        .show_high(show_high), .score(score_a), .high_score(high_a),
        .disp_value(disp_a), .state(state_a), .new_high(nh_a)
    );

    snake_score_keeper #(.POINTS_PER_FOOD(PTS), .MAX_SCORE(MAXB), .ALT_CYCLES(ALT)) u_dut_b (
        .clk(clk), .rst(rst), .start(start), .eat(eat), .game_over(game_over),
        .show_high(show_high), .score(score_b), .high_score(high_b),
        .disp_value(disp_b), .state(state_b), .new_high(nh_b)
    );

    typedef struct {
        int unsigned score;
        int unsigned high;
        int unsigned disp;
        int unsigned st;
        int unsigned nh;
    } exp_t;

    exp_t sb[$];

    int vectors = 0;
    int miscompares = 0;

    // Reference model: game phase 0=idle 1=play 2=over, display phase derived
    // from the number of cycles spent in the over phase.
    int unsigned m_score[2], m_high[2], m_disp[2], m_st[2], m_nh[2], m_ocnt[2];
    int unsigned m_max[2];
    bit p_start, p_eat, p_go;

    initial begin
        m_max[0] = MAXA;
        m_max[1] = MAXB;
    end

    task automatic push_all();
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            e.score = m_score[k];
            e.high  = m_high[k];
            e.disp  = m_disp[k];
            e.st    = m_st[k];
            e.nh    = m_nh[k];
            sb.push_back(e);
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                m_score[k] = 0; m_high[k] = 0; m_disp[k] = 0;
                m_st[k] = 0; m_nh[k] = 0; m_ocnt[k] = 0;
            end
            p_start = 0; p_eat = 0; p_go = 0;
            sb.delete();
            push_all();
        end else begin
            bit se, ee, ge;
            int unsigned nd;
            se = start && !p_start;
            ee = eat && !p_eat;
            ge = game_over && !p_go;
            for (int k = 0; k < 2; k++) begin
                if (m_st[k] == 2)
                    nd = (((m_ocnt[k] / ALT) % 2) == 1) ? m_high[k] : m_score[k];
                else
                    nd = show_high ? m_high[k] : m_score[k];
                if (m_st[k] == 0 || m_st[k] == 2) begin
                    if (se) begin
                        m_st[k] = 1; m_score[k] = 0; m_nh[k] = 0;
                    end else if (m_st[k] == 2) begin
                        m_ocnt[k]++;
                    end
                end else begin
                    if (ee)
                        m_score[k] = (m_score[k] + PTS > m_max[k]) ? m_max[k] : m_score[k] + PTS;
                    if (ge) begin
                        m_st[k] = 2;
                        m_ocnt[k] = 0;
                        if (m_score[k] > m_high[k]) begin
                            m_high[k] = m_score[k];
                            m_nh[k] = 1;
                        end
                    end
                end
                m_disp[k] = nd;
            end
            p_start = start; p_eat = eat; p_go = game_over;
            sb.delete();
            push_all();
        end
    end

    task automatic chk(input string name, input int k, input logic [31:0] act, input int unsigned exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s inst%0d t=%0t got=%0d expected=%0d", name, k, $time, act, exp);
        end
    endtask

    // Monitor: outputs are valid every cycle; compare away from the rising edge.
    always @(negedge clk) begin
        exp_t ea, eb;
        if (sb.size() < 2) begin
            vectors++;
            miscompares++;
            $display("FAIL sb_empty t=%0t got=%0d expected=2", $time, sb.size());
        end else begin
            ea = sb.pop_front();
            eb = sb.pop_front();
            chk("score",      0, 32'(score_a), ea.score);
            chk("high_score", 0, 32'(high_a),  ea.high);
            chk("disp_value", 0, 32'(disp_a),  ea.disp);
            chk("state",      0, 32'(state_a), ea.st);
            chk("new_high",   0, 32'(nh_a),    ea.nh);
            chk("score",      1, 32'(score_b), eb.score);
            chk("high_score", 1, 32'(high_b),  eb.high);
            chk("disp_value", 1, 32'(disp_b),  eb.disp);
            chk("state",      1, 32'(state_b), eb.st);
            chk("new_high",   1, 32'(nh_b),    eb.nh);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic pulse(input int which);
        case (which)
            0: start = 1'b1;
            1: eat = 1'b1;
            default: game_over = 1'b1;
        endcase
        cyc(1);
        start = 1'b0; eat = 1'b0; game_over = 1'b0;
        cyc(1);
    endtask

    initial begin
        #1 rst = 1'b0;
        cyc(2);
        rst = 1'b1;
        cyc(1);

        // First game: three foods, peek at high score, then game over.
        pulse(0);
        repeat (3) pulse(1);
        cyc(2);
        show_high = 1'b1; cyc(2); show_high = 1'b0;
        pulse(2);
        show_high = 1'b1;
        cyc(10);
        show_high = 1'b0;

        // Second game below the high score.
        pulse(0);
        pulse(1);
        pulse(2);
        cyc(10);

        // Third game: saturation on the low-ceiling instance, then
        // simultaneous eat and game_over.
        pulse(0);
        repeat (4) pulse(1);
        eat = 1'b1; game_over = 1'b1;
        cyc(1);
        eat = 1'b0; game_over = 1'b0;
        cyc(10);

        // Fourth game: reset mid-play between edges, eat held through release.
        pulse(0);
        repeat (7) pulse(1);
        #1 rst = 1'b0;
        eat = 1'b1;
        cyc(2);
        rst = 1'b1;
        cyc(3);
        eat = 1'b0;
        cyc(2);

        // Randomised play with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            start     = ($urandom_range(0, 19) == 0);
            eat       = ($urandom_range(0, 2) == 0);
            game_over = ($urandom_range(0, 29) == 0);
            show_high = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 499) == 0) begin
                rst = 1'b0;
                cyc(1);
                rst = 1'b1;
            end
            cyc(1);
        end
        start = 1'b0; eat = 1'b0; game_over = 1'b0; show_high = 1'b0;
        cyc(3);
        @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
